bam_pipe_mac: RTL and testbench

BAM_PIPE_MAC -- requirements
Module: bam_pipe_mac

---
 rtl/bam_pkg.sv | 17 +
 rtl/bam_pipe_mac_if.sv | 28 ++
 rtl/bam_approx_mult.sv | 27 ++
 rtl/bam_pipe_mac.sv | 88 ++++++++
 tb/tb_bam_pipe_mac.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bam_pkg.sv
// Shared definitions for the bit-array-masked (BAM) approximate MAC pipeline.
package bam_pkg;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Valid bits of the two operand/product stages; the third stage's valid is out_valid.
    typedef struct packed {
        logic s1;
        logic s2;
    } stage_valid_t;

    function automatic int prod_width(input int dw, input int ww);
        return dw + ww;
    endfunction

endpackage

// File: rtl/bam_pipe_mac_if.sv
// Streaming input beats and completed dot-product results of bam_pipe_mac.
interface bam_pipe_mac_if #(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int ACCW = 32,
    parameter int VBLW = $clog2(DW + WW)
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [WW-1:0]   in_b;
    logic [VBLW-1:0] in_vbl;
    logic            in_first;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_acc;

    modport master (
        output in_valid, in_a, in_b, in_vbl, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_acc
    );

    modport slave (
        input  in_valid, in_a, in_b, in_vbl, in_first, in_last, out_ready,
        output in_ready, out_valid, out_acc
    );
endinterface

// File: rtl/bam_approx_mult.sv
// Approximate unsigned multiplier: partial-product bits below weight vbl are dropped.
module bam_approx_mult
    import bam_pkg::*;
#(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int VBLW = $clog2(DW + WW)
) (
    input  logic [DW-1:0]                  a,
    input  logic [WW-1:0]                  b,
    input  logic [VBLW-1:0]                vbl,
    output logic [prod_width(DW, WW)-1:0]  p
);
    localparam int PW = prod_width(DW, WW);

    always_comb begin
        // NOTE: p gets a default before the loops so no path leaves it unassigned (no latch).
        p = '0;
        for (int i = 0; i < DW; i++) begin
            for (int j = 0; j < WW; j++) begin
                if ((i + j) >= int'(vbl))
                    p = p + (PW'(a[i] & b[j]) << (i + j));
            end
        end
    end

endmodule

// File: rtl/bam_pipe_mac.sv
// Three-stage approximate multiply-accumulate: S1 operands, S2 product, S3 accumulator/result.
module bam_pipe_mac
    import bam_pkg::*;
#(
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int ACCW = 32,
    parameter int SAT  = SAT_WRAP,
    parameter int VBLW = $clog2(DW + WW)
) (
    input  logic           clk,
    input  logic           rst_n,
    bam_pipe_mac_if.slave  bus
);
    localparam int PW = prod_width(DW, WW);
    localparam int SW = ACCW + 1;

    stage_valid_t    vld;
    logic [DW-1:0]   a1;
    logic [WW-1:0]   b1;
    logic [VBLW-1:0] vbl1;
    logic            first1, last1;
    logic [PW-1:0]   p_comb, p2;
    logic            first2, last2;
    logic [ACCW-1:0] acc, acc_base, acc_next, out_acc_q;
    logic [SW-1:0]   sum;
    logic            out_valid_q, stall;

    // A pending result that is not being taken freezes the whole pipe.
    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;

    bam_approx_mult #(.DW(DW), .WW(WW), .VBLW(VBLW)) u_mult (
        .a   (a1),
        .b   (b1),
        .vbl (vbl1),
        .p   (p_comb)
    );

    always_comb begin
        acc_base = first2 ? '0 : acc;
        sum      = {1'b0, acc_base} + SW'(p2);
        if (SAT == SAT_CLAMP && sum[ACCW])
            acc_next = '1;
        else
            acc_next = sum[ACCW-1:0];
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (!stall) begin
            a1     <= bus.in_a;
            b1     <= bus.in_b;
            vbl1   <= bus.in_vbl;
            first1 <= bus.in_first;
            last1  <= bus.in_last;
            p2     <= p_comb;
            first2 <= first1;
            last2  <= last1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld         <= '0;
            acc         <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            vld.s1      <= bus.in_valid;
            vld.s2      <= vld.s1;
            // Not stalled means any held result is consumed this edge, so reload without a bubble.
            out_valid_q <= vld.s2 & last2;
            if (vld.s2) begin
                if (last2) begin
                    acc       <= '0;
                    out_acc_q <= acc_next;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bam_pipe_mac.sv
// Directed self-checking bench for bam_pipe_mac (default 32-bit wrap plus 16-bit wrap/saturate).
module tb_bam_pipe_mac;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [31:0] got[$];
    int          got_cyc[$];

    always #5 clk = ~clk;

    bam_pipe_mac_if #(.DW(8), .WW(8), .ACCW(32)) m ();
    bam_pipe_mac_if #(.DW(8), .WW(8), .ACCW(16)) mw ();
    bam_pipe_mac_if #(.DW(8), .WW(8), .ACCW(16)) ms ();

    bam_pipe_mac #(.DW(8), .WW(8), .ACCW(32), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(m));
    bam_pipe_mac #(.DW(8), .WW(8), .ACCW(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(mw));
    bam_pipe_mac #(.DW(8), .WW(8), .ACCW(16), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ms));

    always @(posedge clk) cyc <= cyc + 1;

    // Result scoreboard: every handshake on the main DUT is logged with its cycle.
    always @(negedge clk) begin
        if (rst_n && m.out_valid && m.out_ready) begin
            got.push_back(m.out_acc);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m.in_valid  = 0; m.in_first  = 0; m.in_last  = 0;
        m.in_a      = 0; m.in_b      = 0; m.in_vbl   = 0; m.out_ready  = 1;
        mw.in_valid = 0; mw.in_first = 0; mw.in_last = 0;
        mw.in_a     = 0; mw.in_b     = 0; mw.in_vbl  = 0; mw.out_ready = 1;
        ms.in_valid = 0; ms.in_first = 0; ms.in_last = 0;
        ms.in_a     = 0; ms.in_b     = 0; ms.in_vbl  = 0; ms.out_ready = 1;
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] vbl, input logic first, input logic last);
        bit done = 0;
        m.in_a = a; m.in_b = b; m.in_vbl = vbl;
        m.in_first = first; m.in_last = last; m.in_valid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = m.in_ready;
            tick();
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_beat: in_ready stuck at 0, required 1");
        end
        m.in_valid = 0;
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 60) begin
            tick();
            k++;
        end
        tests++;
        if (got.size() != n) begin
            fails++;
            $display("FAIL %s count: got %0d results, required %0d", name, got.size(), n);
        end
    endtask

    task automatic drive_ovf(input logic [7:0] a, input logic [7:0] b,
                             input logic first, input logic last, input logic valid);
        mw.in_a = a; mw.in_b = b; mw.in_first = first; mw.in_last = last; mw.in_valid = valid;
        ms.in_a = a; ms.in_b = b; ms.in_first = first; ms.in_last = last; ms.in_valid = valid;
        tick();
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        repeat (2) tick();
        tests += 3;
        if (m.in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b required 1", m.in_ready); end
        if (m.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b required 0", m.out_valid); end
        if (m.out_acc !== 32'd0) begin fails++; $display("FAIL reset out_acc: got %0d required 0", m.out_acc); end
        rst_n = 1;
        tick();
        tests++;
        if (m.in_ready !== 1'b1) begin fails++; $display("FAIL post-reset in_ready: got %b required 1", m.in_ready); end
    endtask

    task automatic test_exact();
        send_beat(8'd255, 8'd255, 4'd0, 1, 1);
        tests++;
        if (m.out_valid !== 1'b0) begin fails++; $display("FAIL exact edge1 out_valid: got %b required 0", m.out_valid); end
        tick();
        tests++;
        if (m.out_valid !== 1'b0) begin fails++; $display("FAIL exact edge2 out_valid: got %b required 0", m.out_valid); end
        tick();
        tests += 2;
        if (m.out_valid !== 1'b1) begin fails++; $display("FAIL exact edge3 out_valid: got %b required 1", m.out_valid); end
        if (m.out_acc !== 32'd65025) begin fails++; $display("FAIL exact out_acc: got %0d required 65025", m.out_acc); end
        tick();
        tests++;
        if (m.out_valid !== 1'b0) begin fails++; $display("FAIL exact drain out_valid: got %b required 0", m.out_valid); end
    endtask

    task automatic test_break_level();
        got.delete(); got_cyc.delete();
        send_beat(8'd15,  8'd15,  4'd4,  1, 1);
        send_beat(8'd255, 8'd255, 4'd14, 1, 1);
        send_beat(8'd255, 8'd255, 4'd15, 1, 1);
        send_beat(8'd255, 8'd255, 4'd1,  1, 1);
        wait_results(4, "break_level");
        tests += 4;
        if (got[0] !== 32'd176)   begin fails++; $display("FAIL vbl4 15x15: got %0d required 176", got[0]); end
        if (got[1] !== 32'd16384) begin fails++; $display("FAIL vbl14 255x255: got %0d required 16384", got[1]); end
        if (got[2] !== 32'd0)     begin fails++; $display("FAIL vbl15 255x255: got %0d required 0", got[2]); end
        if (got[3] !== 32'd65024) begin fails++; $display("FAIL vbl1 255x255: got %0d required 65024", got[3]); end
    endtask

    task automatic test_dot_product();
        got.delete(); got_cyc.delete();
        send_beat(8'd10, 8'd10, 4'd0, 1, 0);
        send_beat(8'd20, 8'd20, 4'd0, 0, 0);
        send_beat(8'd3,  8'd7,  4'd0, 0, 1);
        wait_results(1, "dot_product");
        tests++;
        if (got[0] !== 32'd521) begin fails++; $display("FAIL dot_product: got %0d required 521", got[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v[5] = '{32'd2, 32'd12, 32'd30, 32'd6, 32'd21};
        got.delete(); got_cyc.delete();
        send_beat(8'd1, 8'd2, 4'd0, 1, 1);
        send_beat(8'd3, 8'd4, 4'd0, 1, 1);
        send_beat(8'd5, 8'd6, 4'd0, 1, 1);
        send_beat(8'd2, 8'd3, 4'd0, 0, 1);
        send_beat(8'd4, 8'd5, 4'd0, 0, 0);
        send_beat(8'd1, 8'd1, 4'd0, 0, 1);
        wait_results(5, "back_to_back");
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin
                fails++; $display("FAIL back_to_back result %0d: got %0d required %0d", i, got[i], exp_v[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_cyc[i+1] - got_cyc[i] != 1) begin
                fails++; $display("FAIL back_to_back gap %0d: got %0d cycles required 1", i, got_cyc[i+1] - got_cyc[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_v[3] = '{32'd42, 32'd72, 32'd110};
        got.delete(); got_cyc.delete();
        m.out_ready = 0;
        fork
            begin
                send_beat(8'd6,  8'd7,  4'd0, 1, 1);
                send_beat(8'd8,  8'd9,  4'd0, 1, 1);
                send_beat(8'd10, 8'd11, 4'd0, 1, 1);
            end
            begin
                int k = 0;
                while (!m.out_valid && k < 20) begin
                    tick();
                    k++;
                end
                for (int i = 0; i < 5; i++) begin
                    tests += 2;
                    if (m.in_ready !== 1'b0) begin fails++; $display("FAIL stall in_ready cycle %0d: got %b required 0", i, m.in_ready); end
                    if (m.out_acc !== 32'd42) begin fails++; $display("FAIL stall out_acc cycle %0d: got %0d required 42", i, m.out_acc); end
                    tick();
                end
                m.out_ready = 1;
            end
        join
        wait_results(3, "backpressure");
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got[i] !== exp_v[i]) begin
                fails++; $display("FAIL backpressure result %0d: got %0d required %0d", i, got[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        got.delete(); got_cyc.delete();
        send_beat(8'd5, 8'd5, 4'd0, 1, 0);
        send_beat(8'd6, 8'd6, 4'd0, 0, 0);
        #2 rst_n = 0;
        #1;
        tests += 2;
        if (m.out_valid !== 1'b0) begin fails++; $display("FAIL mid-reset out_valid: got %b required 0", m.out_valid); end
        if (m.in_ready !== 1'b1) begin fails++; $display("FAIL mid-reset in_ready: got %b required 1", m.in_ready); end
        repeat (2) tick();
        rst_n = 1;
        repeat (6) tick();
        tests++;
        if (got.size() != 0) begin fails++; $display("FAIL mid-reset spurious output: got %0d results required 0", got.size()); end
        send_beat(8'd6, 8'd7, 4'd0, 1, 1);
        wait_results(1, "after_reset");
        tests++;
        if (got[0] !== 32'd42) begin fails++; $display("FAIL after_reset 6x7: got %0d required 42", got[0]); end
    endtask

    task automatic test_overflow();
        drive_ovf(8'd255, 8'd255, 1, 0, 1);
        drive_ovf(8'd255, 8'd255, 0, 1, 1);
        drive_ovf(8'd0,   8'd0,   0, 0, 0);
        tick();
        tests += 4;
        if (mw.out_valid !== 1'b1) begin fails++; $display("FAIL ovf wrap out_valid: got %b required 1", mw.out_valid); end
        if (mw.out_acc !== 16'd64514) begin fails++; $display("FAIL ovf wrap 2 beats: got %0d required 64514", mw.out_acc); end
        if (ms.out_valid !== 1'b1) begin fails++; $display("FAIL ovf sat out_valid: got %b required 1", ms.out_valid); end
        if (ms.out_acc !== 16'd65535) begin fails++; $display("FAIL ovf sat 2 beats: got %0d required 65535", ms.out_acc); end
        drive_ovf(8'd255, 8'd255, 1, 0, 1);
        drive_ovf(8'd255, 8'd255, 0, 0, 1);
        drive_ovf(8'd1,   8'd1,   0, 1, 1);
        drive_ovf(8'd0,   8'd0,   0, 0, 0);
        tick();
        tests += 2;
        if (mw.out_acc !== 16'd64515) begin fails++; $display("FAIL ovf wrap 3 beats: got %0d required 64515", mw.out_acc); end
        if (ms.out_acc !== 16'd65535) begin fails++; $display("FAIL ovf sat held: got %0d required 65535", ms.out_acc); end
    endtask

    initial begin
        test_reset();
        test_exact();
        repeat (4) tick();
        test_break_level();
        repeat (4) tick();
        test_dot_product();
        repeat (4) tick();
        test_back_to_back();
        repeat (4) tick();
        test_backpressure();
        repeat (4) tick();
        test_reset_mid();
        repeat (4) tick();
        test_overflow();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
